// File: rtl/panel_ctrl_arbiter_pkg.sv
// Shared widths, state encoding and helpers for the panel control write-bus arbiter.
package panel_ctrl_arbiter_pkg;
    localparam int PANEL_IDX_W = 3;
    localparam int CTRL_WR_W   = 4;
    localparam int CTRL_ADDR_W = 16;
    localparam int CTRL_WDAT_W = 24;
    localparam int CNT_W       = 8;

    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    typedef struct packed {
        logic [PANEL_IDX_W-1:0] panel;
        logic [CTRL_WR_W-1:0]   wr;
        logic [CTRL_ADDR_W-1:0] addr;
        logic [CTRL_WDAT_W-1:0] wdat;
        logic                   last;
    } beat_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/panel_ctrl_arbiter_if.sv
// Requester beat buses plus the shared panel control write bus.
interface panel_ctrl_arbiter_if
    import panel_ctrl_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_PANELS = 5
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ*PANEL_IDX_W-1:0] req_panel;
    logic [NUM_REQ*CTRL_WR_W-1:0]   req_wr;
    logic [NUM_REQ*CTRL_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*CTRL_WDAT_W-1:0] req_wdat;
    logic [NUM_PANELS-1:0]          ctrl_en;
    logic [CTRL_WR_W-1:0]           ctrl_wr;
    logic [CTRL_ADDR_W-1:0]         ctrl_addr;
    logic [CTRL_WDAT_W-1:0]         ctrl_wdat;

    modport master (
        output req_valid, req_last, req_panel, req_wr, req_addr, req_wdat,
        input  req_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );
    modport slave (
        input  req_valid, req_last, req_panel, req_wr, req_addr, req_wdat,
        output req_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );
endinterface

// File: rtl/panel_ctrl_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from last+1 with wrap.
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);
    int c;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = N; k >= 1; k--) begin
            c = (int'(last) + k) % N;
            if (req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end
endmodule

// File: rtl/panel_ctrl_arbiter.sv
// Grants whole bursts round-robin onto the panel control bus, decodes panel index
// to one-hot ctrl_en, and releases the bus when a granted requester stalls.
module panel_ctrl_arbiter
    import panel_ctrl_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int NUM_PANELS = 5,
    parameter  int TIMEOUT    = 1024,
    localparam int GW         = $clog2(NUM_REQ),
    localparam int WD_W       = $clog2(TIMEOUT)
) (
    input  logic                 clock,
    input  logic                 resetn,
    panel_ctrl_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     timeout_count
);
    state_t                 state, state_n;
    logic [GW-1:0]          last_grant, pick;
    logic                   found;
    logic [WD_W-1:0]        wd_cnt, wd_inc;
    logic [NUM_REQ-1:0]     ready;
    logic                   beat, done, wd_fire;
    logic                   sel_valid, sel_last, panel_ok;
    logic [PANEL_IDX_W-1:0] sel_panel;
    logic [CTRL_WR_W-1:0]   sel_wr;
    logic [CTRL_ADDR_W-1:0] sel_addr;
    logic [CTRL_WDAT_W-1:0] sel_wdat;
    logic [NUM_PANELS-1:0]  en_q;
    logic [CTRL_WR_W-1:0]   wr_q;
    logic [CTRL_ADDR_W-1:0] addr_q;
    logic [CTRL_WDAT_W-1:0] wdat_q;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .last  (last_grant),
        .found (found),
        .idx   (pick)
    );

    assign sel_valid = bus.req_valid[grant_id];
    assign sel_last  = bus.req_last[grant_id];
    assign sel_panel = bus.req_panel[int'(grant_id)*PANEL_IDX_W +: PANEL_IDX_W];
    assign sel_wr    = bus.req_wr[int'(grant_id)*CTRL_WR_W +: CTRL_WR_W];
    assign sel_addr  = bus.req_addr[int'(grant_id)*CTRL_ADDR_W +: CTRL_ADDR_W];
    assign sel_wdat  = bus.req_wdat[int'(grant_id)*CTRL_WDAT_W +: CTRL_WDAT_W];
    assign panel_ok  = int'(sel_panel) < NUM_PANELS;
    assign wd_inc    = wd_cnt + 1'b1;

    always_comb begin
        state_n = state;
        ready   = '0;
        beat    = 1'b0;
        done    = 1'b0;
        wd_fire = 1'b0;
        case (state)
            ST_IDLE: if (found) state_n = ST_BURST;
            ST_BURST: begin
                ready[grant_id] = 1'b1;
                beat            = sel_valid;
                done            = sel_valid & sel_last;
                // Release once the count of beatless cycles would hit TIMEOUT-1.
                wd_fire         = !sel_valid && (wd_inc == WD_W'(TIMEOUT - 1));
                if (done || wd_fire) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            last_grant    <= GW'(NUM_REQ - 1);
            grant_id      <= '0;
            wd_cnt        <= '0;
            err_count     <= '0;
            timeout_count <= '0;
            en_q          <= '0;
            wr_q          <= '0;
            addr_q        <= '0;
            wdat_q        <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && found) begin
                grant_id <= pick;
                wd_cnt   <= '0;
            end else if (beat) begin
                wd_cnt <= '0;
            end else if (state == ST_BURST) begin
                wd_cnt <= wd_inc;
            end
            if (done || wd_fire) last_grant <= grant_id;
            if (wd_fire) timeout_count <= sat_inc(timeout_count);
            if (beat) begin
                addr_q <= sel_addr;
                wdat_q <= sel_wdat;
                en_q   <= panel_ok ? NUM_PANELS'(1) << sel_panel : '0;
                wr_q   <= panel_ok ? sel_wr : '0;
                if (!panel_ok) err_count <= sat_inc(err_count);
            end else begin
                en_q <= '0;
                wr_q <= '0;
            end
        end
    end

    assign busy          = (state == ST_BURST);
    assign bus.req_ready = ready;
    assign bus.ctrl_en   = en_q;
    assign bus.ctrl_wr   = wr_q;
    assign bus.ctrl_addr = addr_q;
    assign bus.ctrl_wdat = wdat_q;
endmodule

// File: tb/tb_panel_ctrl_arbiter.sv
// Directed scoreboard bench for panel_ctrl_arbiter: drivers push expected writes and grants,
// an independent monitor pops and compares whenever the DUT presents them.
module tb_panel_ctrl_arbiter;
    import panel_ctrl_arbiter_pkg::*;
    localparam int NR = 2, NP = 5, TO = 16;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    panel_ctrl_arbiter_if #(.NUM_REQ(NR), .NUM_PANELS(NP)) bus();
    logic       busy;
    logic [0:0] grant_id;
    logic [7:0] err_count, timeout_count;

    panel_ctrl_arbiter #(.NUM_REQ(NR), .NUM_PANELS(NP), .TIMEOUT(TO)) dut (
        .clock(clock), .resetn(resetn), .bus(bus.slave),
        .busy(busy), .grant_id(grant_id),
        .err_count(err_count), .timeout_count(timeout_count)
    );

    typedef struct {
        logic [NP-1:0] en;
        logic [3:0]    wr;
        logic [15:0]   addr;
        logic [23:0]   wdat;
        int            cyc;
    } exp_t;

    exp_t  exp_q[$];
    int    gnt_q[$];
    beat_t rq[NR][$];
    int    n_chk = 0, n_fail = 0, cyc = 0, fall_cyc = 0;
    bit    chk_gap = 0, gap_arm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int p, input int w, input int a, input int d, input bit l);
        beat_t b;
        b.panel = 3'(p); b.wr = 4'(w); b.addr = 16'(a); b.wdat = 24'(d); b.last = l;
        return b;
    endfunction

    // Requester drivers: accept sampled before the edge, committed just after it.
    initial begin
        logic [NR-1:0] acc;
        beat_t b;
        exp_t e;
        bus.req_valid = '0; bus.req_last = '0; bus.req_panel = '0;
        bus.req_wr = '0; bus.req_addr = '0; bus.req_wdat = '0;
        forever begin
            @(negedge clock);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clock);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (acc[r] && resetn && rq[r].size() != 0) begin
                    b = rq[r].pop_front();
                    if (int'(b.panel) < NP) begin
                        e.en = NP'(1) << b.panel; e.wr = b.wr; e.addr = b.addr;
                        e.wdat = b.wdat; e.cyc = cyc + 1;
                        exp_q.push_back(e);
                    end
                end
                b = (rq[r].size() != 0) ? rq[r][0] : '0;
                bus.req_valid[r]            = (rq[r].size() != 0);
                bus.req_last[r]             = b.last;
                bus.req_panel[r*3 +: 3]     = b.panel;
                bus.req_wr[r*4 +: 4]        = b.wr;
                bus.req_addr[r*16 +: 16]    = b.addr;
                bus.req_wdat[r*24 +: 24]    = b.wdat;
            end
        end
    end

    // Monitor
    initial begin
        bit pbusy = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!resetn) begin
                pbusy = 0;
            end else begin
                if (bus.ctrl_en != '0) begin
                    if (exp_q.size() == 0) chk("unexpected_en", 32'(bus.ctrl_en), 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("ctrl_en", 32'(bus.ctrl_en), 32'(e.en));
                        chk("ctrl_wr", 32'(bus.ctrl_wr), 32'(e.wr));
                        chk("ctrl_addr", 32'(bus.ctrl_addr), 32'(e.addr));
                        chk("ctrl_wdat", 32'(bus.ctrl_wdat), 32'(e.wdat));
                        chk("latency", 32'(cyc), 32'(e.cyc));
                    end
                end else begin
                    chk("idle_wr", 32'(bus.ctrl_wr), 0);
                end
                chk("ready", 32'(bus.req_ready), busy ? 32'(NR'(1) << grant_id) : 0);
                if (busy && !pbusy) begin
                    if (gnt_q.size() == 0) chk("unexpected_grant", 1, 0);
                    else chk("grant", 32'(grant_id), 32'(gnt_q.pop_front()));
                    if (chk_gap) begin
                        if (gap_arm) chk("idle_gap", 32'(cyc - fall_cyc), 1);
                        gap_arm = 1;
                    end
                end
                if (!busy && pbusy) fall_cyc = cyc;
                pbusy = busy;
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while ((rq[0].size() != 0 || rq[1].size() != 0 || busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) chk({name, "_timeout"}, 1, 0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int n;
        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_en", 32'(bus.ctrl_en), 0);
        chk("rst_wr", 32'(bus.ctrl_wr), 0);
        chk("rst_addr", 32'(bus.ctrl_addr), 0);
        chk("rst_wdat", 32'(bus.ctrl_wdat), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_to", 32'(timeout_count), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ready", 32'(bus.req_ready), 0);

        // Single 3-beat burst to panel 2
        for (int i = 0; i < 3; i++) rq[0].push_back(mk(2, 1, 'h0100 + i, 'hFF0000, i == 2));
        gnt_q.push_back(0);
        wait_done("single");
        chk("single_gid", 32'(grant_id), 0);

        // Invalid panel beat, then a valid beat to panel 4
        chk("err_before", 32'(err_count), 0);
        rq[1].push_back(mk(7, 'hF, 'h0200, 'h00FF00, 0));
        rq[1].push_back(mk(4, 2, 'h0201, 'h0000FF, 1));
        gnt_q.push_back(1);
        wait_done("invalid");
        chk("err_after", 32'(err_count), 1);

        // Contention: both requesters with two 2-beat bursts each
        chk_gap = 1; gap_arm = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                rq[0].push_back(mk(0, 3, 'h1000 + k*16 + i, 'h123456 + k, i == 1));
                rq[1].push_back(mk(3, 5, 'h2000 + k*16 + i, 'h654321 + k, i == 1));
            end
            gnt_q.push_back(0);
            gnt_q.push_back(1);
        end
        wait_done("contention");
        chk_gap = 0;

        // Watchdog: req0 stalls after one beat, req1 waiting
        rq[0].push_back(mk(1, 4, 'h3000, 'hABCDEF, 0));
        gnt_q.push_back(0);
        n = 0;
        while (rq[0].size() != 0 && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) chk("wd_beat_timeout", 1, 0);
        rq[1].push_back(mk(3, 6, 'h3100, 'h0F0F0F, 1));
        gnt_q.push_back(1);
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clock); end
        chk("wd_cycles", 32'(n), 15);
        chk("wd_count", 32'(timeout_count), 1);
        wait_done("watchdog");
        chk("wd_count_hold", 32'(timeout_count), 1);

        // Reset in the middle of a 4-beat burst
        for (int i = 0; i < 4; i++) rq[0].push_back(mk(1, 7, 'h4000 + i, 'h777777, i == 3));
        gnt_q.push_back(0);
        n = 0;
        while (rq[0].size() > 3 && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) chk("mid_rst_timeout", 1, 0);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 0);
        chk("mid_rst_en", 32'(bus.ctrl_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_to", 32'(timeout_count), 0);
        chk("mid_rst_err", 32'(err_count), 0);
        repeat (2) @(negedge clock);
        rq[0].delete();
        rq[1].push_back(mk(0, 8, 'h5000, 'h111111, 1));
        rq[0].push_back(mk(2, 9, 'h5100, 'h222222, 1));
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        @(negedge clock);
        #1 resetn = 1'b1;
        wait_done("post_rst");

        chk("exp_q_empty", 32'(exp_q.size()), 0);
        chk("gnt_q_empty", 32'(gnt_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/panel_ctrl_arbiter.md
Name: panel_ctrl_arbiter

Overview:
Shares the single panel control write bus (ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat) that fans out to the five ledpanel instances among several write requesters, e.g. the UDP panel writer and a local test-pattern or overlay source. Each requester issues bursts of beats tagged with a panel index. The arbiter grants one whole burst at a time in round-robin order and decodes the panel index to the one-hot ctrl_en. A watchdog frees the bus when a granted requester stalls.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
NUM_PANELS, 5, number of panels; width of ctrl_en
TIMEOUT, 1024, idle cycles inside a burst before forced release (>=2)

Ports:
clock  in  1  system clock; single clock domain
resetn  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accept
req_last  in  NUM_REQ  beat is the last of its burst
req_panel  in  NUM_REQ*3  panel index per requester, flattened, requester 0 in LSBs
req_wr  in  NUM_REQ*4  colour-block write select per requester
req_addr  in  NUM_REQ*16  {col,row} address per requester
req_wdat  in  NUM_REQ*24  {R,G,B} data per requester
ctrl_en  out  NUM_PANELS  one-hot panel write enable
ctrl_wr  out  4  colour-block select to panels
ctrl_addr  out  16  write address to panels
ctrl_wdat  out  24  write data to panels
busy  out  1  a burst is granted
grant_id  out  clog2(NUM_REQ)  current or last granted requester
err_count  out  8  saturating count of beats with panel index >= NUM_PANELS
timeout_count  out  8  saturating count of watchdog releases

Behaviour:
- Reset (asynchronous, resetn=0):
  - All outputs are 0. State is IDLE. last_grant = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, BURST.
- IDLE:
  - req_ready is all 0.
  - If any req_valid is set, pick the first valid requester searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register the pick as g, set busy=1 and grant_id=g, and enter BURST on the next cycle. Arbitration latency is 1 cycle.
  - If no req_valid is set, stay in IDLE.
- BURST:
  - req_ready[g]=1, driven combinationally from state. All other ready bits are 0.
  - Beat = req_valid[g] & req_ready[g].
  - On a beat, the next cycle shows ctrl_en = onehot(req_panel[g]) and ctrl_wr/ctrl_addr/ctrl_wdat = requester g's fields. Output register latency is exactly 1 cycle.
  - Without a beat, the next cycle shows ctrl_en=0 and ctrl_wr=0; ctrl_addr and ctrl_wdat hold.
  - A beat with req_last[g]=1 is the final beat. Next cycle: IDLE, busy=0, last_grant=g.
  - A new grant appears no earlier than one IDLE cycle after a burst ends.
- Watchdog:
  - wd_cnt clears on entering BURST and on every beat.
  - It increments on each BURST cycle without a beat.
  - When wd_cnt reaches TIMEOUT-1 with no beat: go to IDLE, set last_grant=g, increment timeout_count (saturating at 255), and drive ready low from the next cycle.
- Invalid panel index (>= NUM_PANELS):
  - The beat is still accepted and counts for last/watchdog.
  - ctrl_en stays all 0, ctrl_wr is forced to 0, and err_count increments (saturating at 255).
- No downstream backpressure: the panel RAM write ports always accept, so ready never depends on the ctrl outputs.
- Simultaneous valid from all requesters: strictly round-robin. No requester waits more than NUM_REQ-1 bursts.
- Single-beat burst (valid & last on the first beat): legal; produces one ctrl_en pulse.
- Requester g drops valid mid-burst: the grant is held until last or timeout.
- Reset asserted mid-burst: all outputs clear immediately, including ready and ctrl_en; the partial burst is abandoned.

Decomposition:
- Shared package/include holds:
  - Field widths: PANEL_IDX_W=3, CTRL_WR_W=4, CTRL_ADDR_W=16, CTRL_WDAT_W=24, CNT_W=8.
  - State encodings: ST_IDLE, ST_BURST.
- One combinational sub-module, rr_pick. Inputs: request vector and last_grant. Outputs: found flag and index. It is reusable for other shared resources.

Test Plan:
- Reset values: hold resetn=0 -> all outputs 0. Release with no valid -> stays IDLE, ready=00.
- Single burst: req0 sends 3 beats to panel 2, addr 0x0100/0x0101/0x0102, wdat 0xFF0000, last on beat 3 -> ctrl_en=00100 on three cycles, each 1 cycle after its beat; busy falls after the last beat; grant_id=0.
- Contention: req0 and req1 both continuously send 2-beat bursts -> grant order 0,1,0,1; each burst separated by exactly one IDLE cycle; ready is never high on both requesters.
- Invalid panel: req1 sends a beat with panel=7, wr=0xF -> ctrl_en=00000, ctrl_wr=0, err_count 0->1; the next valid beat with panel=4 -> ctrl_en=10000.
- Watchdog: with TIMEOUT=16, req0 sends 1 beat without last, then drops valid -> after 15 beatless cycles state returns to IDLE, timeout_count=1, and a pending req1 is granted next.
- Reset mid-burst: assert resetn=0 during beat 2 of a 4-beat burst -> ready, ctrl_en and busy are 0 in the same cycle. After release, req1 pending -> requester 0 still has first priority (last_grant reset to 1).
